servo_cmd_parser: RTL and testbench

//  Receive-side parser for the servo ASCII command protocol "#iiiPppppTtttt!":
//  3-digit servo ID, 4-digit pulse width in us, 4-digit move time in ms.

---
 rtl/servo_cmd_parser.sv | 194 +++++++++++++++++++
 tb/tb_servo_cmd_parser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_cmd_parser.sv
// Receive-side parser for the "#iiiPppppTtttt!" servo command protocol.
// Converts the decimal fields to binary and emits one validated command or error strobe per frame.
module servo_cmd_parser #(
  parameter int PULSE_MIN      = 500,
  parameter int PULSE_MAX      = 2500,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_valid,
  output logic [9:0]  cmd_id,
  output logic [13:0] cmd_pulse,
  output logic [13:0] cmd_time,
  output logic        cmd_error,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SEP_P, S_PULSE, S_SEP_T, S_TIME, S_END
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_CHAR = 2'd0,
    ERR_ABORT    = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_RANGE    = 2'd3
  } err_t;

  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [13:0]   P_MIN   = 14'(PULSE_MIN);
  localparam logic [13:0]   P_MAX   = 14'(PULSE_MAX);

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_END  = 8'h21;

  state_t            state_q, state_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [9:0]        id_acc_q, id_acc_d;
  logic [13:0]       pulse_acc_q, pulse_acc_d;
  logic [13:0]       time_acc_q, time_acc_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              valid_d, error_d, load_cmd, bad;
  logic [1:0]        err_code_d;
  logic              is_digit, is_hash;
  logic [3:0]        digit;

  function automatic logic [13:0] mac10(input logic [13:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {10'd0, d};
  endfunction

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_hash  = (rx_data == CH_HASH);
  assign digit    = rx_data[3:0];
  assign busy     = (state_q != S_IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    id_acc_d    = id_acc_q;
    pulse_acc_d = pulse_acc_q;
    time_acc_d  = time_acc_q;
    tcnt_d      = (state_q == S_IDLE) ? '0 : tcnt_q + 1'b1;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code;
    load_cmd    = 1'b0;
    bad         = 1'b0;

    if (rx_valid) begin
      tcnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (is_hash) begin
            state_d     = S_ID;
            dcnt_d      = '0;
            id_acc_d    = '0;
            pulse_acc_d = '0;
            time_acc_d  = '0;
          end
        end
        S_ID: begin
          if (is_digit) begin
            id_acc_d = 10'(mac10({4'd0, id_acc_q}, digit));
            if (dcnt_q == 2'd2) begin
              state_d = S_SEP_P;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 2'd1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        S_SEP_P: if (rx_data == CH_P) state_d = S_PULSE; else bad = 1'b1;
        S_PULSE: begin
          if (is_digit) begin
            pulse_acc_d = mac10(pulse_acc_q, digit);
            dcnt_d      = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) state_d = S_SEP_T;
          end else begin
            bad = 1'b1;
          end
        end
        S_SEP_T: if (rx_data == CH_T) state_d = S_TIME; else bad = 1'b1;
        S_TIME: begin
          if (is_digit) begin
            time_acc_d = mac10(time_acc_q, digit);
            dcnt_d     = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) state_d = S_END;
          end else begin
            bad = 1'b1;
          end
        end
        S_END: begin
          if (rx_data == CH_END) begin
            state_d = S_IDLE;
            if (pulse_acc_q >= P_MIN && pulse_acc_q <= P_MAX) begin
              valid_d  = 1'b1;
              load_cmd = 1'b1;
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_RANGE;
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A stray '#' mid-frame both reports the abort and starts the new frame.
      if (bad) begin
        error_d = 1'b1;
        if (is_hash) begin
          err_code_d  = ERR_ABORT;
          state_d     = S_ID;
          dcnt_d      = '0;
          id_acc_d    = '0;
          pulse_acc_d = '0;
          time_acc_d  = '0;
        end else begin
          err_code_d = ERR_BAD_CHAR;
          state_d    = S_IDLE;
        end
      end
    end else if (state_q != S_IDLE && tcnt_q == TO_LAST) begin
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = S_IDLE;
      tcnt_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      id_acc_q    <= '0;
      pulse_acc_q <= '0;
      time_acc_q  <= '0;
      tcnt_q      <= '0;
      cmd_valid   <= 1'b0;
      cmd_error   <= 1'b0;
      err_code    <= '0;
      cmd_id      <= '0;
      cmd_pulse   <= '0;
      cmd_time    <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      id_acc_q    <= id_acc_d;
      pulse_acc_q <= pulse_acc_d;
      time_acc_q  <= time_acc_d;
      tcnt_q      <= tcnt_d;
      cmd_valid   <= valid_d;
      cmd_error   <= error_d;
      err_code    <= err_code_d;
      if (load_cmd) begin
        cmd_id    <= id_acc_q;
        cmd_pulse <= pulse_acc_q;
        cmd_time  <= time_acc_q;
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_parser.sv
// Directed-vector bench for servo_cmd_parser with a short timeout (100 cycles).
// Expected values are hand-computed from the protocol frames.
module tb_servo_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmd_valid, cmd_error, busy;
  logic [9:0]  cmd_id;
  logic [13:0] cmd_pulse, cmd_time;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_seen = 0;
  int error_seen = 0;
  int both_seen = 0;

  servo_cmd_parser #(
    .PULSE_MIN(500), .PULSE_MAX(2500), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_pulse(cmd_pulse), .cmd_time(cmd_time),
    .cmd_error(cmd_error), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe tally sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid) valid_seen++;
      if (cmd_error) error_seen++;
      if (cmd_valid && cmd_error) both_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s.getc(i)));
  endtask

  task automatic check_cmd(input string tag, input int id, input int pulse, input int tm);
    check({tag, "_id"},    32'(cmd_id),    32'(id));
    check({tag, "_pulse"}, 32'(cmd_pulse), 32'(pulse));
    check({tag, "_time"},  32'(cmd_time),  32'(tm));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_error"}, 32'(cmd_error), 32'd0);
    check({tag, "_code"},  32'(err_code),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check_cmd(tag, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int v0, e0, n;
    logic fired;

    #12;
    check_outputs_zero("reset");
    rst = 1'b1;
    tick(2);
    check_outputs_zero("post_reset");

    // Basic frame.
    v0 = valid_seen; e0 = error_seen;
    send_str("#003P1500T1000!");
    check("t1_valid", 32'(cmd_valid), 32'd1);
    check("t1_error", 32'(cmd_error), 32'd0);
    check_cmd("t1", 3, 1500, 1000);
    check("t1_busy", 32'(busy), 32'd0);
    tick(1);
    check("t1_valid_one_cycle", 32'(cmd_valid), 32'd0);
    check("t1_valid_count", 32'(valid_seen - v0), 32'd1);
    check("t1_error_count", 32'(error_seen - e0), 32'd0);

    // Pulse below minimum: RANGE, outputs held.
    send_str("#012P0400T0500!");
    check("t2_error", 32'(cmd_error), 32'd1);
    check("t2_code", 32'(err_code), 32'd3);
    check("t2_valid", 32'(cmd_valid), 32'd0);
    check_cmd("t2", 3, 1500, 1000);
    tick(1);
    check("t2_error_one_cycle", 32'(cmd_error), 32'd0);
    check("t2_code_held", 32'(err_code), 32'd3);

    // Pulse just above maximum.
    send_str("#001P2501T0001!");
    check("range_hi_error", 32'(cmd_error), 32'd1);
    check("range_hi_code", 32'(err_code), 32'd3);
    check_cmd("range_hi", 3, 1500, 1000);

    // Abort by '#', then re-synced frame at PULSE_MAX.
    send_str("#00#");
    check("t3_abort_error", 32'(cmd_error), 32'd1);
    check("t3_abort_code", 32'(err_code), 32'd1);
    check("t3_abort_busy", 32'(busy), 32'd1);
    send_str("001P2500T0000!");
    check("t3_valid", 32'(cmd_valid), 32'd1);
    check_cmd("t3", 1, 2500, 0);

    // Bad char, then frame at PULSE_MIN and max field values.
    send_str("#0A");
    check("t4_bad_error", 32'(cmd_error), 32'd1);
    check("t4_bad_code", 32'(err_code), 32'd0);
    check("t4_bad_busy", 32'(busy), 32'd0);
    send_str("#999P0500T9999!");
    check("t4_valid", 32'(cmd_valid), 32'd1);
    check_cmd("t4", 999, 500, 9999);

    // Timeout fires exactly 100 cycles after the last byte.
    send_str("#005P15");
    n = 0;
    fired = 1'b0;
    while (n < 200 && !fired) begin
      tick(1);
      n++;
      if (cmd_error) fired = 1'b1;
    end
    check("t5_timeout_fired", 32'(fired), 32'd1);
    check("t5_timeout_latency", 32'(n), 32'd100);
    check("t5_timeout_code", 32'(err_code), 32'd2);
    check("t5_timeout_busy", 32'(busy), 32'd0);

    // Byte arriving on cycle 100 wins over the timeout.
    tick(1);
    e0 = error_seen;
    send_str("#005P15");
    tick(99);
    send_byte("0");
    check("t5_late_byte_no_error", 32'(cmd_error), 32'd0);
    check("t5_late_byte_busy", 32'(busy), 32'd1);
    send_str("0T0001!");
    check("t5_late_valid", 32'(cmd_valid), 32'd1);
    check_cmd("t5_late", 5, 1500, 1);
    tick(1);
    check("t5_late_error_count", 32'(error_seen - e0), 32'd0);

    // Noise in IDLE is ignored.
    v0 = valid_seen; e0 = error_seen;
    send_str("xyz!");
    tick(1);
    check("t6_noise_valid_count", 32'(valid_seen - v0), 32'd0);
    check("t6_noise_error_count", 32'(error_seen - e0), 32'd0);
    check("t6_noise_busy", 32'(busy), 32'd0);

    // Async reset mid-frame clears everything, next frame parses.
    send_str("#00");
    #2;
    rst = 1'b0;
    #2;
    check_outputs_zero("t6_rst");
    tick(2);
    rst = 1'b1;
    tick(1);
    v0 = valid_seen; e0 = error_seen;
    send_str("#042P1000T0250!");
    check("t6_valid", 32'(cmd_valid), 32'd1);
    check_cmd("t6", 42, 1000, 250);
    tick(1);
    check("t6_valid_count", 32'(valid_seen - v0), 32'd1);
    check("t6_error_count", 32'(error_seen - e0), 32'd0);

    check("never_both_strobes", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
